// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module   : popcount_pkg
// Purpose  : Shared types and helpers for the popcount accumulator slice.
// Revision : 1.0  initial release
// ============================================================================
package popcount_pkg;

    typedef enum logic {
        MODE_CUMUL  = 1'b0,
        MODE_WINDOW = 1'b1
    } mode_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_tree.sv
`default_nettype none
// ============================================================================
// Module   : popcount_tree
// Purpose  : Combinational balanced adder tree returning the set-bit count.
// Revision : 1.0  initial release
// ============================================================================
module popcount_tree
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] in_data,
    output logic [CNT_W-1:0] count
);

    localparam int c_lvls   = $clog2(WIDTH);
    localparam int c_leaves = 1 << c_lvls;

    // Leaves are padded to a power of two so every level halves cleanly.
    for (genvar l = 0; l <= c_lvls; l++) begin : g_lvl
        logic [CNT_W-1:0] w_sum [0:(c_leaves >> l)-1];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < c_leaves; i++) begin : g_bit
                if (i < WIDTH) begin : g_real
                    assign w_sum[i] = CNT_W'(in_data[i]);
                end else begin : g_pad
                    assign w_sum[i] = '0;
                end
            end
        end else begin : g_add
            for (genvar i = 0; i < (c_leaves >> l); i++) begin : g_node
                assign w_sum[i] = g_lvl[l-1].w_sum[2*i] + g_lvl[l-1].w_sum[2*i+1];
            end
        end
    end

    assign count = g_lvl[c_lvls].w_sum[0];

endmodule
`default_nettype wire

// File: rtl/popcount_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : popcount_accumulator
// Purpose  : Registered popcount with cumulative/windowed saturating totals.
// Revision : 1.0  initial release
// ============================================================================
module popcount_accumulator
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int ACC_W = 16,
    parameter  int LEN_W = 8,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    input  logic [LEN_W-1:0] window_len,
    input  logic             clear,
    output logic             out_valid,
    output logic [CNT_W-1:0] count,
    output logic             total_valid,
    output logic [ACC_W-1:0] total,
    output logic             sat
);

    state_t           r_state, w_nxt_state;
    mode_t            r_mode, w_nxt_mode;
    logic [LEN_W-1:0] r_len, w_nxt_len;
    logic [ACC_W-1:0] r_acc, w_nxt_acc;
    logic [LEN_W-1:0] r_smp, w_nxt_smp;
    logic [ACC_W-1:0] r_total, w_nxt_total;
    logic             r_total_valid, w_nxt_total_valid;
    logic [CNT_W-1:0] r_count, w_nxt_count;
    logic             r_out_valid, w_nxt_out_valid;
    logic             r_sat, w_nxt_sat;
    logic             r_win_clip, w_nxt_win_clip;

    logic [CNT_W-1:0] w_pc;
    logic [ACC_W:0]   w_sum_ext;
    logic             w_clip;
    logic [ACC_W-1:0] w_sum;
    mode_t            w_eff_mode;
    logic [LEN_W-1:0] w_eff_len;
    logic [LEN_W-1:0] w_smp_next;
    logic             w_close;

    popcount_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .in_data (in_data),
        .count   (w_pc)
    );

    assign w_sum_ext = {1'b0, r_acc} + (ACC_W+1)'(w_pc);
    assign w_clip    = w_sum_ext[ACC_W];
    assign w_sum     = w_clip ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

    // Mode and length are sampled only while idle; a window in progress keeps its settings.
    assign w_eff_mode = (r_state == S_IDLE) ? mode_t'(mode) : r_mode;
    assign w_eff_len  = (r_state == S_IDLE)
                      ? ((window_len == '0) ? LEN_W'(1) : window_len)
                      : r_len;
    assign w_smp_next = r_smp + LEN_W'(1);
    assign w_close    = (w_smp_next == w_eff_len);

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_mode        = r_mode;
        w_nxt_len         = r_len;
        w_nxt_acc         = r_acc;
        w_nxt_smp         = r_smp;
        w_nxt_total       = r_total;
        w_nxt_total_valid = 1'b0;
        w_nxt_count       = r_count;
        w_nxt_out_valid   = 1'b0;
        w_nxt_sat         = r_sat;
        w_nxt_win_clip    = r_win_clip;

        if (clear) begin
            w_nxt_state    = S_IDLE;
            w_nxt_acc      = '0;
            w_nxt_smp      = '0;
            w_nxt_total    = '0;
            w_nxt_sat      = 1'b0;
            w_nxt_win_clip = 1'b0;
        end else if (in_valid) begin
            w_nxt_count     = w_pc;
            w_nxt_out_valid = 1'b1;
            w_nxt_mode      = w_eff_mode;
            w_nxt_len       = w_eff_len;
            if (w_eff_mode == MODE_CUMUL) begin
                w_nxt_state       = S_ACCUM;
                w_nxt_acc         = w_sum;
                w_nxt_total       = w_sum;
                w_nxt_total_valid = 1'b1;
                w_nxt_sat         = r_sat | w_clip;
            end else if (w_close) begin
                w_nxt_state       = S_IDLE;
                w_nxt_acc         = '0;
                w_nxt_smp         = '0;
                w_nxt_total       = w_sum;
                w_nxt_total_valid = 1'b1;
                w_nxt_sat         = r_win_clip | w_clip;
                w_nxt_win_clip    = 1'b0;
            end else begin
                w_nxt_state    = S_ACCUM;
                w_nxt_acc      = w_sum;
                w_nxt_smp      = w_smp_next;
                w_nxt_win_clip = r_win_clip | w_clip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mode        <= MODE_CUMUL;
            r_len         <= '0;
            r_acc         <= '0;
            r_smp         <= '0;
            r_total       <= '0;
            r_total_valid <= 1'b0;
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_sat         <= 1'b0;
            r_win_clip    <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_mode        <= w_nxt_mode;
            r_len         <= w_nxt_len;
            r_acc         <= w_nxt_acc;
            r_smp         <= w_nxt_smp;
            r_total       <= w_nxt_total;
            r_total_valid <= w_nxt_total_valid;
            r_count       <= w_nxt_count;
            r_out_valid   <= w_nxt_out_valid;
            r_sat         <= w_nxt_sat;
            r_win_clip    <= w_nxt_win_clip;
        end
    end

    assign out_valid   = r_out_valid;
    assign count       = r_count;
    assign total_valid = r_total_valid;
    assign total       = r_total;
    assign sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_popcount_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount_accumulator
// Purpose  : Directed self-checking bench for popcount_accumulator.
// Revision : 1.0  initial release
// ============================================================================
module tb_popcount_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        mode;
    logic [7:0]  window_len;
    logic        clear;

    logic        out_valid, total_valid, sat;
    logic [2:0]  count;
    logic [15:0] total;

    logic        out_valid_s, total_valid_s, sat_s;
    logic [2:0]  count_s;
    logic [2:0]  total_s;

    int vectors     = 0;
    int miscompares = 0;
    int run_total;

    popcount_accumulator #(.WIDTH(4), .ACC_W(16), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .mode(mode), .window_len(window_len), .clear(clear),
        .out_valid(out_valid), .count(count), .total_valid(total_valid),
        .total(total), .sat(sat)
    );

    popcount_accumulator #(.WIDTH(4), .ACC_W(3), .LEN_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .mode(mode), .window_len(window_len), .clear(clear),
        .out_valid(out_valid_s), .count(count_s), .total_valid(total_valid_s),
        .total(total_s), .sat(sat_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Applies one cycle of inputs and returns 1 time unit after the sampling edge.
    task automatic step(input logic v, input logic [3:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
        window_len = 8'd0; clear = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_total_valid", 32'(total_valid), 0);
        chk("rst_total", 32'(total), 0);
        chk("rst_sat", 32'(sat), 0);
        rst_n = 1'b1;

        // Exhaustive count in cumulative mode
        mode = 1'b0;
        run_total = 0;
        for (int v = 0; v < 16; v++) begin
            step(1'b1, 4'(v), 1'b0);
            run_total += $countones(4'(v));
            chk("exh_count", 32'(count), 32'($countones(4'(v))));
            chk("exh_out_valid", 32'(out_valid), 1);
            chk("exh_total_valid", 32'(total_valid), 1);
            chk("exh_total", 32'(total), 32'(run_total));
        end
        chk("exh_final_total", 32'(total), 32);
        step(1'b0, 4'h0, 1'b0);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_total_valid", 32'(total_valid), 0);
        chk("idle_total_hold", 32'(total), 32);
        chk("idle_count_hold", 32'(count), 4);
        step(1'b0, 4'h0, 1'b1);
        chk("clr_total", 32'(total), 0);
        chk("clr_sat", 32'(sat), 0);

        // Window of 3
        mode = 1'b1; window_len = 8'd3;
        step(1'b1, 4'b1111, 1'b0);
        chk("w3_tv1", 32'(total_valid), 0);
        chk("w3_count1", 32'(count), 4);
        step(1'b1, 4'b0001, 1'b0);
        chk("w3_tv2", 32'(total_valid), 0);
        chk("w3_total_hold", 32'(total), 0);
        step(1'b1, 4'b0110, 1'b0);
        chk("w3_tv3", 32'(total_valid), 1);
        chk("w3_total", 32'(total), 7);
        step(1'b0, 4'h0, 1'b0);
        chk("w3_tv_after", 32'(total_valid), 0);
        chk("w3_total_kept", 32'(total), 7);

        // window_len = 0 behaves as 1
        window_len = 8'd0;
        step(1'b1, 4'b1010, 1'b0);
        chk("w0_tv1", 32'(total_valid), 1);
        chk("w0_total1", 32'(total), 2);
        step(1'b1, 4'b0111, 1'b0);
        chk("w0_tv2", 32'(total_valid), 1);
        chk("w0_total2", 32'(total), 3);

        // Saturation on the 3-bit accumulator instance
        step(1'b0, 4'h0, 1'b1);
        mode = 1'b0;
        step(1'b1, 4'b1111, 1'b0);
        chk("sat_total1", 32'(total_s), 4);
        chk("sat_flag1", 32'(sat_s), 0);
        step(1'b1, 4'b1111, 1'b0);
        chk("sat_total2", 32'(total_s), 7);
        chk("sat_flag2", 32'(sat_s), 1);
        step(1'b1, 4'b1111, 1'b0);
        chk("sat_total3", 32'(total_s), 7);
        chk("sat_flag3", 32'(sat_s), 1);
        chk("wide_total3", 32'(total), 12);
        chk("wide_sat3", 32'(sat), 0);
        step(1'b0, 4'h0, 1'b1);
        chk("sat_clr_total", 32'(total_s), 0);
        chk("sat_clr_flag", 32'(sat_s), 0);

        // Clear colliding with a valid sample mid-window
        mode = 1'b1; window_len = 8'd4;
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        chk("cc_tv_partial", 32'(total_valid), 0);
        step(1'b1, 4'b1111, 1'b1);
        chk("cc_tv", 32'(total_valid), 0);
        chk("cc_out_valid", 32'(out_valid), 0);
        chk("cc_count_hold", 32'(count), 1);
        chk("cc_total", 32'(total), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0001, 1'b0);
            chk("cc_tv_mid", 32'(total_valid), 0);
        end
        step(1'b1, 4'b0001, 1'b0);
        chk("cc_tv_end", 32'(total_valid), 1);
        chk("cc_total_end", 32'(total), 4);

        // Asynchronous reset in the middle of a window
        window_len = 8'd5;
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_total_valid", 32'(total_valid), 0);
        chk("ar_total", 32'(total), 0);
        chk("ar_sat", 32'(sat), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b0011, 1'b0);
            chk("ar_tv_mid", 32'(total_valid), 0);
        end
        step(1'b1, 4'b0011, 1'b0);
        chk("ar_tv_end", 32'(total_valid), 1);
        chk("ar_total_end", 32'(total), 10);
        step(1'b0, 4'h0, 1'b0);
        chk("ar_tv_drop", 32'(total_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/popcount_accumulator.md
# popcount_accumulator

Parametrised, clocked population-count block. It counts the set bits of a WIDTH-bit sample each valid cycle and registers the result. It also accumulates those counts, either as a running total or over programmable windows of samples, with saturation and a sticky overflow flag. It generalises the 4-input combinational bit counter and sits between sampled status/event vectors and the statistics readout logic.

## Interface
Parameters:
- WIDTH, 4, bits per input sample (≥1)
- ACC_W, 16, accumulator/total width (≥ CNT_W)
- LEN_W, 8, width of window length field

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample qualifier
- in_data  in  WIDTH  sample vector
- mode  in  1  0 = cumulative, 1 = windowed
- window_len  in  LEN_W  samples per window in windowed mode; 0 treated as 1
- clear  in  1  synchronous flush of accumulation state
- out_valid  out  1  count holds a new sample result
- count  out  CNT_W  popcount of last accepted sample, CNT_W = $clog2(WIDTH+1)
- total_valid  out  1  one-cycle pulse: total updated
- total  out  ACC_W  accumulated count
- sat  out  1  sticky: accumulation clipped at all-ones

## Operation
- Sample is accepted on a rising edge with in_valid=1 and clear=0. pc = popcount(in_data), range 0..WIDTH.
- count ← pc and out_valid ← 1 on accept; otherwise out_valid ← 0 and count holds.
- State machine (state, acc, smp_cnt):
  - IDLE: no sample in the current window. mode and window_len are latched here on the accepting edge and stay fixed until the window ends.
  - ACCUM: at least one sample accumulated.
- Cumulative mode: acc ← sat_add(acc, pc) on every accept; total ← same value; total_valid pulses every accept. State remains ACCUM until clear.
- Windowed mode: acc ← sat_add(acc, pc); smp_cnt increments.
  - On the accept that makes smp_cnt equal the latched length, total ← sat_add(acc, pc) and total_valid pulses.
  - On that same edge acc ← 0, smp_cnt ← 0, state ← IDLE, and sat ← 1 if this window saturated, else 0.
- sat_add clips at 2^ACC_W−1. In cumulative mode sat sets on the first clip and holds until clear.
- window_len=0 behaves as 1: every sample closes a window and total = pc.
- clear=1: acc, smp_cnt, total and sat ← 0; state ← IDLE; total_valid ← 0; out_valid ← 0.
  - clear wins over a simultaneous in_valid, and that sample is dropped.
  - A partial window is discarded with no total_valid.
- Changing mode or window_len mid-window has no effect until the next IDLE.

## Timing
- Reset (rst_n low, async) values: out_valid=0, count=0, total_valid=0, total=0, sat=0; state=IDLE, acc=0, smp_cnt=0.
- Latency: sample accepted at edge k → count/out_valid/total/total_valid visible after edge k (one cycle), all registered outputs.
- Back-to-back in_valid is supported at full rate; no backpressure.
- Windowed: the window-closing sample's contribution is included in the same-cycle total. The first sample of the next window may arrive on the very next edge.
- rst_n asserted mid-window discards everything; there is no total_valid on release.
- total holds its value between pulses.

## Structure
- Package popcount_pkg holds:
  - mode enum (MODE_CUMUL, MODE_WINDOW)
  - state enum (S_IDLE, S_ACCUM)
  - count-width helper function cnt_w(WIDTH) = $clog2(WIDTH+1)
- Sub-module popcount_tree: purely combinational, parametrised balanced adder tree, WIDTH → CNT_W. The top holds all registers, the FSM and the saturating adder.

## Test plan
Run with WIDTH=4 unless noted.
- Exhaustive count: feed all 16 values of in_data 0..15, one per cycle, in cumulative mode. count matches popcount one cycle later (0,1,1,2,…,4), and after the 16th sample total=32.
- Window of 3: mode=1, window_len=3, samples 4'b1111, 4'b0001, 4'b0110. Exactly one total_valid pulse, after the 3rd edge, with total=7. Intermediate cycles show total_valid=0.
- window_len=0: samples 4'b1010 then 4'b0111 in windowed mode. Two total_valid pulses with total=2 then 3.
- Saturation: ACC_W=3, cumulative mode, three samples of 4'b1111. total goes 4, 7 (sat=1), 7 and stays clipped. clear then gives total=0, sat=0.
- Clear collision: windowed, window_len=4, two samples accepted, then clear=1 with in_valid=1 on the same edge. No total_valid and out_valid=0 on that cycle. The next 4 samples of 4'b0001 produce total=4.
- Async reset mid-window: windowed, window_len=5, pulse rst_n low between edges after 2 samples. All outputs read 0 immediately. Then 5 samples of 4'b0011 produce total=10.
